// File: rtl/hub75_scan_seq.sv
// hub75_scan_seq
//   Row/bit-plane scan sequencer for HUB75 LED panels with global brightness.
//   A front FSM requests each (row, plane) shift from a downstream shifter,
//   then blanks, latches and unblanks the panel for that step. A separate
//   display timer holds the panel unblanked for the BCM on-time of the
//   latched plane. Because the timer is separate, the next shift runs while
//   the current plane is displayed.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ctrl_run              1 = scan continuously, 0 = stop at next step boundary
//   cfg_pre_latch_len     blanked cycles before the latch pulse (0 = none)
//   cfg_latch_len         latch pulse length minus 1
//   cfg_post_latch_len    blanked cycles after the latch pulse (0 = none)
//   cfg_bcm_bit_len       plane-0 display period minus 1
//   cfg_brightness        global on-fraction (b+1)/256
//   shift_req/row/plane   shift request towards the pixel shifter
//   shift_ack             one-cycle pulse: requested shift is complete
//   hub75_addr/le/blank   panel row address, latch enable, blank
//   frame_done            one-cycle pulse after the last row/plane is latched
module hub75_scan_seq #(
    parameter int N_ROWS    = 32,
    parameter int N_PLANES  = 8,
    parameter int BCM_LEN_W = 8,
    localparam int LOG_N_ROWS = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int PLANE_W    = (N_PLANES > 1) ? $clog2(N_PLANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_run,
    input  logic [7:0]            cfg_pre_latch_len,
    input  logic [7:0]            cfg_latch_len,
    input  logic [7:0]            cfg_post_latch_len,
    input  logic [BCM_LEN_W-1:0]  cfg_bcm_bit_len,
    input  logic [7:0]            cfg_brightness,
    output logic                  shift_req,
    output logic [LOG_N_ROWS-1:0] shift_row,
    output logic [PLANE_W-1:0]    shift_plane,
    input  logic                  shift_ack,
    output logic [LOG_N_ROWS-1:0] hub75_addr,
    output logic                  hub75_le,
    output logic                  hub75_blank,
    output logic                  frame_done
);

    // Timer width: period (BCM_LEN_W + N_PLANES bits) times (brightness+1)
    // (9 bits) never overflows.
    localparam int TW = BCM_LEN_W + N_PLANES + 9;
    localparam logic [TW-1:0]         T_ZERO     = {TW{1'b0}};
    localparam logic [TW-1:0]         T_ONE      = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [LOG_N_ROWS-1:0] ROW_LAST   = LOG_N_ROWS'(N_ROWS - 1);
    localparam logic [LOG_N_ROWS-1:0] ROW_ONE    = {{(LOG_N_ROWS-1){1'b0}}, 1'b1};
    localparam logic [PLANE_W-1:0]    PLANE_LAST = PLANE_W'(N_PLANES - 1);
    localparam logic [PLANE_W-1:0]    PLANE_ONE  = {{(PLANE_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PRE   = 3'd3,
        ST_LATCH = 3'd4,
        ST_POST  = 3'd5
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [7:0]              cnt_r, cnt_nxt_s;
    logic                    step_done_s;
    logic                    last_step_s;
    logic                    timer_idle_s;
    logic [TW-1:0]           dur_s, prod_s, on_s, off_s;
    logic [TW-1:0]           on_cnt_r, off_cnt_r;
    logic                    shift_req_r, le_r, blank_r, frame_done_r;
    logic [LOG_N_ROWS-1:0]   shift_row_r, addr_r;
    logic [PLANE_W-1:0]      shift_plane_r;

    assign shift_req   = shift_req_r;
    assign shift_row   = shift_row_r;
    assign shift_plane = shift_plane_r;
    assign hub75_addr  = addr_r;
    assign hub75_le    = le_r;
    assign hub75_blank = blank_r;
    assign frame_done  = frame_done_r;

    assign timer_idle_s = (on_cnt_r == T_ZERO) && (off_cnt_r == T_ZERO);
    assign last_step_s  = (shift_row_r == ROW_LAST) && (shift_plane_r == PLANE_LAST);

    // Display period and on-time for the plane currently held in shift_plane_r.
    always_comb begin
        dur_s  = ({{(TW-BCM_LEN_W){1'b0}}, cfg_bcm_bit_len} + T_ONE) << shift_plane_r;
        prod_s = dur_s * ({{(TW-8){1'b0}}, cfg_brightness} + T_ONE);
        on_s   = prod_s >> 4'd8;
        off_s  = dur_s - on_s;
    end

    // Front FSM next-state and phase counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        step_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_run) state_nxt_s = ST_SHIFT;
                else          state_nxt_s = ST_IDLE;
            end
            ST_SHIFT: begin
                // shift_req_r is high throughout SHIFT; the qualifier keeps a
                // stray ack from ever advancing the FSM.
                if (shift_req_r && shift_ack) state_nxt_s = ST_WAIT;
                else                          state_nxt_s = ST_SHIFT;
            end
            ST_WAIT: begin
                // The previous plane must finish before the panel is relatched.
                if (!timer_idle_s) begin
                    state_nxt_s = ST_WAIT;
                end else if (cfg_pre_latch_len != 8'd0) begin
                    state_nxt_s = ST_PRE;
                    cnt_nxt_s   = cfg_pre_latch_len - 8'd1;
                end else begin
                    state_nxt_s = ST_LATCH;
                    cnt_nxt_s   = cfg_latch_len;
                end
            end
            ST_PRE: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_LATCH;
                    cnt_nxt_s   = cfg_latch_len;
                end else begin
                    cnt_nxt_s   = cnt_r - 8'd1;
                end
            end
            ST_LATCH: begin
                if (cnt_r != 8'd0) begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end else if (cfg_post_latch_len != 8'd0) begin
                    state_nxt_s = ST_POST;
                    cnt_nxt_s   = cfg_post_latch_len - 8'd1;
                end else begin
                    step_done_s = 1'b1;
                    if (ctrl_run) state_nxt_s = ST_SHIFT;
                    else          state_nxt_s = ST_IDLE;
                end
            end
            ST_POST: begin
                if (cnt_r != 8'd0) begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end else begin
                    step_done_s = 1'b1;
                    if (ctrl_run) state_nxt_s = ST_SHIFT;
                    else          state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // FSM state, counter and registered panel/shift control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            shift_req_r  <= 1'b0;
            le_r         <= 1'b0;
            addr_r       <= {LOG_N_ROWS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            shift_req_r  <= (state_nxt_s == ST_SHIFT);
            le_r         <= (state_nxt_s == ST_LATCH);
            frame_done_r <= step_done_s && last_step_s;
            // Address only moves on LATCH entry, when the display timer is idle.
            if ((state_nxt_s == ST_LATCH) && (state_r != ST_LATCH)) addr_r <= shift_row_r;
            else                                                     addr_r <= addr_r;
        end
    end

    // Scan position: advances once per completed step and survives a stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_row_r   <= {LOG_N_ROWS{1'b0}};
            shift_plane_r <= {PLANE_W{1'b0}};
        end else if (step_done_s) begin
            if (shift_plane_r == PLANE_LAST) begin
                shift_plane_r <= {PLANE_W{1'b0}};
                if (shift_row_r == ROW_LAST) shift_row_r <= {LOG_N_ROWS{1'b0}};
                else                         shift_row_r <= shift_row_r + ROW_ONE;
            end else begin
                shift_plane_r <= shift_plane_r + PLANE_ONE;
            end
        end else begin
            shift_row_r   <= shift_row_r;
            shift_plane_r <= shift_plane_r;
        end
    end

    // Display timer: on-phase (unblanked) then off-phase (blanked), then idle.
    // blank_r always equals (on_cnt_r == 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_cnt_r  <= T_ZERO;
            off_cnt_r <= T_ZERO;
            blank_r   <= 1'b1;
        end else if (step_done_s) begin
            on_cnt_r  <= on_s;
            off_cnt_r <= off_s;
            blank_r   <= (on_s == T_ZERO);
        end else if (on_cnt_r != T_ZERO) begin
            on_cnt_r  <= on_cnt_r - T_ONE;
            blank_r   <= (on_cnt_r == T_ONE);
        end else if (off_cnt_r != T_ZERO) begin
            off_cnt_r <= off_cnt_r - T_ONE;
            blank_r   <= 1'b1;
        end else begin
            blank_r   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hub75_scan_seq.sv
// tb_hub75_scan_seq
//   Bench for hub75_scan_seq (4 rows, 8 planes). A shifter model acks shift
//   requests after a chosen delay; each ack pushes the step the reference
//   model expects (position, phase lengths, BCM on-time, frame flag). A
//   monitor on the falling clock edge pops those steps and checks the shift
//   position, latch address/width/start time, unblank timing/length,
//   frame_done and the panel invariants.
module tb_hub75_scan_seq;

    localparam int NR = 4;
    localparam int NP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ctrl_run;
    logic [7:0] cfg_pre, cfg_lat, cfg_post, cfg_bcm, cfg_bright;
    logic       shift_req, shift_ack;
    logic [1:0] shift_row, hub75_addr;
    logic [2:0] shift_plane;
    logic       hub75_le, hub75_blank, frame_done;

    hub75_scan_seq #(.N_ROWS(NR), .N_PLANES(NP), .BCM_LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_run(ctrl_run),
        .cfg_pre_latch_len(cfg_pre), .cfg_latch_len(cfg_lat),
        .cfg_post_latch_len(cfg_post), .cfg_bcm_bit_len(cfg_bcm),
        .cfg_brightness(cfg_bright),
        .shift_req(shift_req), .shift_row(shift_row), .shift_plane(shift_plane),
        .shift_ack(shift_ack),
        .hub75_addr(hub75_addr), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     row;
        int     plane;
        int     pre;
        int     lat;
        int     post;
        longint d;
        longint on;
        bit     frm;
    } step_t;

    step_t  exp_q[$];
    step_t  pend_q[$];

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    int     n_acks = 0;
    int     m_row = 0, m_plane = 0;
    bit     mon_en = 1'b0, resp_en = 1'b0, spur_en = 1'b0;
    bit     ack_rand = 1'b0;
    int     ack_fix = 0, ack_max = 0;
    longint idle_cyc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint lmax(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Shifter model: acks each request after a delay and records what the
    // reference model expects from that step.
    initial begin
        int    wcnt;
        step_t s;
        wcnt = -1;
        shift_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            shift_ack = 1'b0;
            if (!resp_en) begin
                wcnt = -1;
            end else if (shift_req) begin
                if (wcnt < 0) wcnt = ack_rand ? int'($urandom_range(0, ack_max)) : ack_fix;
                if (wcnt == 0) begin
                    s.row   = m_row;
                    s.plane = m_plane;
                    s.pre   = int'(cfg_pre);
                    s.lat   = int'(cfg_lat);
                    s.post  = int'(cfg_post);
                    s.d     = (longint'(cfg_bcm) + 1) * (longint'(1) << m_plane);
                    s.on    = (s.d * (longint'(cfg_bright) + 1)) / 256;
                    s.frm   = (m_row == NR - 1) && (m_plane == NP - 1);
                    exp_q.push_back(s);
                    if (m_plane == NP - 1) begin
                        m_plane = 0;
                        m_row   = (m_row + 1) % NR;
                    end else begin
                        m_plane = m_plane + 1;
                    end
                    n_acks++;
                    shift_ack = 1'b1;
                    wcnt = -1;
                end else begin
                    wcnt--;
                end
            end else begin
                wcnt = -1;
                if (spur_en && ($urandom_range(0, 7) == 0)) shift_ack = 1'b1;
            end
        end
    end

    // Monitor: compares observed panel/shift behaviour with queued steps.
    initial begin
        bit     p_le, p_blank;
        logic [1:0] p_addr;
        bit     cur_valid;
        step_t  cur, s;
        longint ack_cyc, le_rise, t0, run_start;
        cur_valid = 1'b0; ack_cyc = -100; le_rise = 0; t0 = -1; run_start = 0;
        p_le = 1'b0; p_blank = 1'b1; p_addr = 2'd0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                cur_valid = 1'b0; ack_cyc = -100; t0 = -1; idle_cyc = 0;
            end else begin
                if (shift_req && shift_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("ack_expected", 0, 1);
                    end else begin
                        s = exp_q.pop_front();
                        chk("shift_row", shift_row, s.row);
                        chk("shift_plane", shift_plane, s.plane);
                        pend_q.push_back(s);
                    end
                    ack_cyc = cyc;
                end
                if (hub75_le && !p_le) begin
                    if (pend_q.size() == 0) begin
                        chk("latch_expected", 0, 1);
                    end else begin
                        // WAIT leaves one cycle after ack or after the timer idles;
                        // then PRE cycles precede the latch pulse.
                        chk("latch_addr", hub75_addr, pend_q[0].row);
                        chk("latch_start", cyc,
                            lmax(ack_cyc + 2, idle_cyc + 1) + pend_q[0].pre);
                    end
                    le_rise = cyc;
                end
                if (hub75_le) chk("le_while_lit", hub75_blank, 1);
                if (!hub75_le && p_le && (pend_q.size() != 0)) begin
                    cur = pend_q.pop_front();
                    chk("latch_width", cyc - le_rise, cur.lat + 1);
                    cur_valid = 1'b1;
                    t0 = cyc + cur.post;
                    idle_cyc = t0 + cur.d;
                end
                if (frame_done || (cur_valid && cyc == t0))
                    chk("frame_done", frame_done, (cur_valid && cyc == t0 && cur.frm) ? 1 : 0);
                if (cur_valid && cyc == t0)
                    chk("unblank_start", hub75_blank, (cur.on == 0) ? 1 : 0);
                if (!hub75_blank && p_blank) run_start = cyc;
                if (hub75_blank && !p_blank)
                    chk("on_cycles", cyc - run_start, cur_valid ? cur.on : -1);
                if (hub75_addr != p_addr) chk("addr_moved_lit", hub75_blank, 1);
            end
            p_le = hub75_le; p_blank = hub75_blank; p_addr = hub75_addr;
        end
    end

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_req", shift_req, 0);
            chk("idle_blank", hub75_blank, 1);
            chk("idle_le", hub75_le, 0);
        end
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (b < 20000 && !(exp_q.size() == 0 && pend_q.size() == 0 &&
                              !shift_req && cyc > idle_cyc + 2)) begin
            @(negedge clk);
            b++;
        end
        if (b >= 20000) chk("idle_timeout", 1, 0);
        check_idle(20);
    endtask

    task automatic run_steps(input int n);
        int target, b;
        target = n_acks + n;
        ctrl_run = 1'b1;
        b = 0;
        while (n_acks < target && b < 20000) begin
            @(negedge clk);
            b++;
        end
        ctrl_run = 1'b0;
        if (n_acks < target) chk("run_timeout", n_acks, target);
        wait_idle();
    endtask

    task automatic set_cfg(input int pre, input int lat, input int post,
                           input int bcm, input int bright);
        cfg_pre = 8'(pre); cfg_lat = 8'(lat); cfg_post = 8'(post);
        cfg_bcm = 8'(bcm); cfg_bright = 8'(bright);
    endtask

    task automatic do_reset();
        mon_en = 1'b0; resp_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", shift_req, 0);
        chk("rst_row", shift_row, 0);
        chk("rst_plane", shift_plane, 0);
        chk("rst_addr", hub75_addr, 0);
        chk("rst_le", hub75_le, 0);
        chk("rst_blank", hub75_blank, 1);
        chk("rst_frame", frame_done, 0);
        exp_q.delete(); pend_q.delete();
        m_row = 0; m_plane = 0;
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1; resp_en = 1'b1;
    endtask

    initial begin
        ctrl_run = 1'b0;
        rst_n = 1'b0;
        set_cfg(2, 0, 1, 6, 255);
        @(negedge clk);
        do_reset();

        // Released with run low: everything stays parked.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("park_addr", hub75_addr, 0);
        end
        check_idle(10);

        // Basic timing, ack two cycles after request; planes 0..7 of row 0.
        ack_rand = 1'b0; ack_fix = 2;
        set_cfg(2, 0, 1, 6, 255);
        run_steps(NP);

        // Half brightness, bcm=7: plane 3 lit 32 of 64 cycles.
        ack_rand = 1'b1; ack_max = 5;
        set_cfg(1, 1, 2, 7, 127);
        run_steps(NP);

        // Immediate acks: every shift finishes early and waits for the display.
        ack_rand = 1'b0; ack_fix = 0;
        set_cfg(0, 2, 0, 3, 200);
        run_steps(NP);

        // Randomised configurations, late/early acks and stray acks.
        spur_en = 1'b1; ack_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ack_max = (r == 3) ? 60 : 12;
            if (r == 0) set_cfg(0, 0, 0, 0, 0);
            else set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 255)));
            run_steps(int'($urandom_range(10, 30)));
        end

        // More than a full frame: frame_done and row/plane wrap.
        ack_max = 4;
        set_cfg(1, 0, 1, 0, 255);
        run_steps(NR * NP + 4);
        spur_en = 1'b0;

        // Reset in the middle of a latch pulse.
        set_cfg(1, 6, 1, 0, 255);
        ctrl_run = 1'b1;
        begin
            int b;
            b = 0;
            while (!hub75_le && b < 2000) begin
                @(negedge clk);
                b++;
            end
            chk("saw_latch", hub75_le, 1);
        end
        mon_en = 1'b0; resp_en = 1'b0; ctrl_run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_le", hub75_le, 0);
        chk("abort_blank", hub75_blank, 1);
        chk("abort_addr", hub75_addr, 0);
        chk("abort_req", shift_req, 0);
        do_reset();
        check_idle(10);

        // After reset, scanning restarts from row 0, plane 0.
        set_cfg(1, 0, 1, 1, 128);
        run_steps(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
